// File: rtl/cmp_seq_arb_if.sv
// Request/result bundle between two compare requesters and the shared
// slice-serial comparator.
interface cmp_seq_arb_if #(parameter int WIDTH = 16);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done0;
    logic             done1;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt, busy, done0, done1, lt, eq, gt
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt, busy, done0, done1, lt, eq, gt
    );
endinterface

// File: rtl/cmp_seq_arb.sv
// Round-robin shared unsigned comparator: two requesters, SLICE bits compared
// per cycle MSB-first, with early termination on the first differing slice.
module cmp_seq_arb #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic         clk,
    input  logic         rst,
    cmp_seq_arb_if.slave bus
);
    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NS - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx_q;
    logic [1:0]       gnt_q;
    logic             ptr_q;
    logic             lt_q, eq_q, gt_q;
    logic             load, pick1;
    logic [SLICE-1:0] a_sl, b_sl;

    // Operands shift left after each equal slice, so the slice under test
    // always sits in the top SLICE bits.
    assign a_sl  = a_q[WIDTH-1 -: SLICE];
    assign b_sl  = b_q[WIDTH-1 -: SLICE];
    assign pick1 = bus.req1 & (~bus.req0 | ptr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (bus.req0 | bus.req1) begin
                load    = 1'b1;
                state_d = CMP;
            end
            CMP:  if ((a_sl != b_sl) || (idx_q == LAST)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            gnt_q <= 2'b00;
            ptr_q <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (load) begin
                    a_q   <= pick1 ? bus.a1 : bus.a0;
                    b_q   <= pick1 ? bus.b1 : bus.b0;
                    gnt_q <= pick1 ? 2'b10 : 2'b01;
                    idx_q <= '0;
                end
                CMP: begin
                    if (a_sl != b_sl) begin
                        lt_q <= (a_sl < b_sl);
                        gt_q <= (a_sl > b_sl);
                        eq_q <= 1'b0;
                    end else if (idx_q == LAST) begin
                        lt_q <= 1'b0;
                        gt_q <= 1'b0;
                        eq_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        a_q   <= a_q << SLICE;
                        b_q   <= b_q << SLICE;
                    end
                end
                DONE: begin
                    // Point at whoever was not just served.
                    ptr_q <= gnt_q[0];
                    gnt_q <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done0 = (state_q == DONE) & gnt_q[0];
    assign bus.done1 = (state_q == DONE) & gnt_q[1];
    assign bus.lt    = lt_q;
    assign bus.eq    = eq_q;
    assign bus.gt    = gt_q;
endmodule
